defuse_sequencer: RTL and testbench

//  Controller for the defuse datapath (defuse_field / defuse_missing). Accepts player defuse

---
 rtl/defuse_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_defuse_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/defuse_sequencer.sv
// rtl/defuse_sequencer.sv - defuse request sequencer: seed write, cascade raster scans, pending slot
module defuse_sequencer #(
  parameter int MAX_PASSES = 16,
  parameter int IDX_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       level_i,
  input  logic             defuse_req_i,
  input  logic [IDX_W-1:0] defuse_ind_x_i,
  input  logic [IDX_W-1:0] defuse_ind_y_i,
  input  logic             cell_changed_i,
  output logic             busy_o,
  output logic             seed_we_o,
  output logic [IDX_W-1:0] seed_x_o,
  output logic [IDX_W-1:0] seed_y_o,
  output logic             scan_valid_o,
  output logic [IDX_W-1:0] scan_x_o,
  output logic [IDX_W-1:0] scan_y_o,
  output logic [4:0]       pass_count_o,
  output logic             done_o,
  output logic             req_drop_o,
  output logic             req_err_o
);

  localparam int NW = IDX_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_SEED, S_SCAN, S_CHECK, S_DONE} state_t;

  state_t           state_q;
  logic [1:0]       level_q;
  logic             dirty_q;
  logic             pend_valid_q;
  logic [IDX_W-1:0] pend_x_q, pend_y_q;
  logic             busy_q, seed_we_q, scan_valid_q, done_q, req_drop_q, req_err_q;
  logic [IDX_W-1:0] seed_x_q, seed_y_q, scan_x_q, scan_y_q;
  logic [4:0]       pass_count_q;

  logic [NW-1:0]    n_w;
  logic             req_ok, lvl_chg, x_last, y_last, can_repeat;
  logic [IDX_W-1:0] req_x0, req_y0;

  always_comb begin
    n_w = '0;
    case (level_i)
      2'd1:    n_w = NW'(8);
      2'd2:    n_w = NW'(10);
      2'd3:    n_w = NW'(16);
      default: n_w = '0;
    endcase
  end

  // level 0 gives n_w = 0, so every index fails the range test
  assign req_ok = (defuse_ind_x_i != '0) && ({1'b0, defuse_ind_x_i} <= n_w) &&
                  (defuse_ind_y_i != '0) && ({1'b0, defuse_ind_y_i} <= n_w);
  assign req_x0     = defuse_ind_x_i - IDX_W'(1);
  assign req_y0     = defuse_ind_y_i - IDX_W'(1);
  assign lvl_chg    = (level_i != level_q);
  assign x_last     = ({1'b0, scan_x_q} == n_w - NW'(1));
  assign y_last     = ({1'b0, scan_y_q} == n_w - NW'(1));
  assign can_repeat = dirty_q && (int'(pass_count_q) + 1 < MAX_PASSES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      level_q      <= '0;
      dirty_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      busy_q       <= 1'b0;
      seed_we_q    <= 1'b0;
      seed_x_q     <= '0;
      seed_y_q     <= '0;
      scan_valid_q <= 1'b0;
      scan_x_q     <= '0;
      scan_y_q     <= '0;
      pass_count_q <= '0;
      done_q       <= 1'b0;
      req_drop_q   <= 1'b0;
      req_err_q    <= 1'b0;
    end else begin
      seed_we_q  <= 1'b0;
      seed_x_q   <= '0;
      seed_y_q   <= '0;
      done_q     <= 1'b0;
      req_drop_q <= 1'b0;
      req_err_q  <= defuse_req_i && !req_ok;
      level_q    <= level_i;
      if (lvl_chg) pend_valid_q <= 1'b0;

      if (state_q != S_IDLE && lvl_chg) begin
        state_q      <= S_IDLE;
        busy_q       <= 1'b0;
        scan_valid_q <= 1'b0;
        scan_x_q     <= '0;
        scan_y_q     <= '0;
      end else begin
        if (state_q != S_IDLE && defuse_req_i && req_ok) begin
          if (pend_valid_q) begin
            req_drop_q <= 1'b1;
          end else begin
            pend_valid_q <= 1'b1;
            pend_x_q     <= req_x0;
            pend_y_q     <= req_y0;
          end
        end
        case (state_q)
          S_IDLE: begin
            if (pend_valid_q && !lvl_chg) begin
              state_q      <= S_SEED;
              busy_q       <= 1'b1;
              seed_we_q    <= 1'b1;
              seed_x_q     <= pend_x_q;
              seed_y_q     <= pend_y_q;
              pass_count_q <= '0;
              dirty_q      <= 1'b0;
              // slot is freed by this start, so a simultaneous request refills it
              pend_valid_q <= defuse_req_i && req_ok;
              pend_x_q     <= req_x0;
              pend_y_q     <= req_y0;
            end else if (defuse_req_i && req_ok) begin
              state_q      <= S_SEED;
              busy_q       <= 1'b1;
              seed_we_q    <= 1'b1;
              seed_x_q     <= req_x0;
              seed_y_q     <= req_y0;
              pass_count_q <= '0;
              dirty_q      <= 1'b0;
            end
          end
          S_SEED: begin
            state_q      <= S_SCAN;
            scan_valid_q <= 1'b1;
            scan_x_q     <= '0;
            scan_y_q     <= '0;
          end
          S_SCAN: begin
            if (cell_changed_i) dirty_q <= 1'b1;
            if (x_last) begin
              scan_x_q <= '0;
              if (y_last) begin
                scan_y_q     <= '0;
                scan_valid_q <= 1'b0;
                state_q      <= S_CHECK;
              end else begin
                scan_y_q <= scan_y_q + IDX_W'(1);
              end
            end else begin
              scan_x_q <= scan_x_q + IDX_W'(1);
            end
          end
          S_CHECK: begin
            if (int'(pass_count_q) < MAX_PASSES) pass_count_q <= pass_count_q + 5'd1;
            if (can_repeat) begin
              dirty_q      <= 1'b0;
              state_q      <= S_SCAN;
              scan_valid_q <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_o       = busy_q;
  assign seed_we_o    = seed_we_q;
  assign seed_x_o     = seed_x_q;
  assign seed_y_o     = seed_y_q;
  assign scan_valid_o = scan_valid_q;
  assign scan_x_o     = scan_x_q;
  assign scan_y_o     = scan_y_q;
  assign pass_count_o = pass_count_q;
  assign done_o       = done_q;
  assign req_drop_o   = req_drop_q;
  assign req_err_o    = req_err_q;

endmodule

// File: tb/tb_defuse_sequencer.sv
// tb/tb_defuse_sequencer.sv - directed table-driven bench for defuse_sequencer
module tb_defuse_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] level;
  logic       req;
  logic [4:0] ind_x, ind_y;
  logic       cell_changed;
  logic       busy, seed_we, scan_valid, done, req_drop, req_err;
  logic [4:0] seed_x, seed_y, scan_x, scan_y, pass_count;

  int checks = 0;
  int passed = 0;

  defuse_sequencer #(.MAX_PASSES(16), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .level_i(level), .defuse_req_i(req),
    .defuse_ind_x_i(ind_x), .defuse_ind_y_i(ind_y), .cell_changed_i(cell_changed),
    .busy_o(busy), .seed_we_o(seed_we), .seed_x_o(seed_x), .seed_y_o(seed_y),
    .scan_valid_o(scan_valid), .scan_x_o(scan_x), .scan_y_o(scan_y),
    .pass_count_o(pass_count), .done_o(done), .req_drop_o(req_drop), .req_err_o(req_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] lvl;
    int         x;
    int         y;
    bit         err;
    int         n;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // mode 0: cell_changed low; 1: hits in passes 1-2 plus high outside scan; 2: always high
  task automatic run_to_done(input int n, input int mode, output int cycles,
                             output int scans, output int dones, output bit coord_ok);
    cycles = 0; scans = 0; dones = 0; coord_ok = 1'b1;
    while (dones == 0 && cycles < 5000) begin
      case (mode)
        1:       cell_changed = !scan_valid || scans == 5 || scans == 456;
        2:       cell_changed = 1'b1;
        default: cell_changed = 1'b0;
      endcase
      step();
      cycles++;
      if (scan_valid) begin
        if (int'(scan_x) != scans % n || int'(scan_y) != (scans / n) % n) coord_ok = 1'b0;
        scans++;
      end else if (scan_x != 0 || scan_y != 0) begin
        coord_ok = 1'b0;
      end
      if (done) dones++;
    end
    cell_changed = 1'b0;
    if (dones == 0) $display("FAIL run_to_done timeout after %0d cycles, expected a done pulse", cycles);
  endtask

  task automatic pulse_req(input int x, input int y);
    ind_x = 5'(x); ind_y = 5'(y); req = 1'b1;
    step();
    req = 1'b0;
  endtask

  int  cyc, scn, dn;
  bit  cok;
  int  bad;

  initial begin
    vecs[0] = '{2'd1, 3, 5, 1'b0, 8};
    vecs[1] = '{2'd2, 11, 1, 1'b1, 10};
    vecs[2] = '{2'd2, 0, 4, 1'b1, 10};
    vecs[3] = '{2'd2, 10, 10, 1'b0, 10};
    vecs[4] = '{2'd0, 1, 1, 1'b1, 0};
    vecs[5] = '{2'd1, 9, 1, 1'b1, 8};
    vecs[6] = '{2'd3, 1, 16, 1'b0, 16};
    vecs[7] = '{2'd1, 8, 8, 1'b0, 8};
    vecs[8] = '{2'd3, 17, 2, 1'b1, 16};

    rst = 1'b1; level = 2'd0; req = 1'b0; ind_x = '0; ind_y = '0; cell_changed = 1'b0;
    repeat (3) step();
    chk("reset_outputs", int'({busy, seed_we, scan_valid, done, req_drop, req_err}), 0);
    chk("reset_pass_count", int'(pass_count), 0);
    chk("reset_coords", int'({seed_x, seed_y, scan_x, scan_y}), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      level = vecs[i].lvl;
      step();
      pulse_req(vecs[i].x, vecs[i].y);
      chk($sformatf("v%0d_req_err", i), int'(req_err), int'(vecs[i].err));
      chk($sformatf("v%0d_seed_we", i), int'(seed_we), int'(!vecs[i].err));
      chk($sformatf("v%0d_busy", i), int'(busy), int'(!vecs[i].err));
      if (!vecs[i].err) begin
        chk($sformatf("v%0d_seed_x", i), int'(seed_x), vecs[i].x - 1);
        chk($sformatf("v%0d_seed_y", i), int'(seed_y), vecs[i].y - 1);
        run_to_done(vecs[i].n, 0, cyc, scn, dn, cok);
        chk($sformatf("v%0d_done_latency", i), cyc, vecs[i].n * vecs[i].n + 2);
        chk($sformatf("v%0d_scan_cycles", i), scn, vecs[i].n * vecs[i].n);
        chk($sformatf("v%0d_scan_order", i), int'(cok), 1);
        chk($sformatf("v%0d_pass_count", i), int'(pass_count), 1);
        chk($sformatf("v%0d_busy_at_done", i), int'(busy), 1);
        step();
        chk($sformatf("v%0d_idle_after", i), int'({busy, done}), 0);
      end else begin
        step();
        chk($sformatf("v%0d_err_pulse_width", i), int'({req_err, busy, seed_we}), 0);
      end
    end

    // three-pass cascade on the hard board
    level = 2'd3;
    step();
    pulse_req(16, 16);
    chk("cascade_seed", int'({seed_we, seed_x, seed_y}), int'({1'b1, 5'd15, 5'd15}));
    run_to_done(16, 1, cyc, scn, dn, cok);
    chk("cascade_scans", scn, 768);
    chk("cascade_cycles", cyc, 3 * 257 + 1);
    chk("cascade_pass_count", int'(pass_count), 3);
    chk("cascade_order", int'(cok), 1);
    bad = 0;
    repeat (5) begin step(); if (done || seed_we || busy) bad++; end
    chk("cascade_single_done", bad, 0);

    // never converges: bounded by MAX_PASSES
    level = 2'd1;
    step();
    pulse_req(1, 1);
    run_to_done(8, 2, cyc, scn, dn, cok);
    chk("maxpass_scans", scn, 16 * 64);
    chk("maxpass_cycles", cyc, 16 * 65 + 1);
    chk("maxpass_pass_count", int'(pass_count), 16);
    step();
    chk("maxpass_pass_hold", int'(pass_count), 16);

    // pending slot: first extra request kept, next two dropped
    pulse_req(1, 1);
    repeat (3) step();
    pulse_req(2, 2);
    chk("pend_first_kept", int'(req_drop), 0);
    pulse_req(3, 3);
    chk("pend_second_drop", int'(req_drop), 1);
    pulse_req(4, 4);
    chk("pend_third_drop", int'(req_drop), 1);
    run_to_done(8, 0, cyc, scn, dn, cok);
    chk("pend_first_done", dn, 1);
    step();
    chk("pend_idle_gap", int'({busy, seed_we}), 0);
    step();
    chk("pend_serviced", int'({seed_we, seed_x, seed_y}), int'({1'b1, 5'd1, 5'd1}));
    run_to_done(8, 0, cyc, scn, dn, cok);
    chk("pend_second_latency", cyc, 66);
    bad = 0;
    repeat (4) begin step(); if (seed_we || busy) bad++; end
    chk("pend_slot_empty", bad, 0);

    // level change mid-scan aborts and discards the pending request
    pulse_req(2, 3);
    repeat (5) step();
    pulse_req(5, 5);
    repeat (5) step();
    level = 2'd2;
    step();
    chk("abort_busy", int'({busy, scan_valid, seed_we, done}), 0);
    bad = 0;
    repeat (150) begin step(); if (done || seed_we || busy || scan_valid) bad++; end
    chk("abort_quiet", bad, 0);

    // asynchronous reset in the middle of a scan
    pulse_req(4, 4);
    repeat (10) step();
    chk("rst_pre_scanning", int'(scan_valid), 1);
    #3 rst = 1'b1;
    #1;
    chk("rst_async_all_zero",
        int'({busy, seed_we, scan_valid, done, req_drop, req_err, pass_count}), 0);
    chk("rst_async_coords", int'({seed_x, seed_y, scan_x, scan_y}), 0);
    step();
    rst = 1'b0;
    bad = 0;
    repeat (5) begin step(); if (done || seed_we || busy || scan_valid) bad++; end
    chk("rst_no_residual", bad, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
